// File: rtl/piso_serial_tx.sv
// piso_serial_tx: valid/ready parallel-in, serial-out transmitter with a frame strobe,
// a last-bit pulse and an optional even-parity bit after the data bits.
module piso_serial_tx #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0,
    parameter int PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             tx_done,
    output logic             busy
);
    localparam int FLEN = WIDTH + (PARITY_EN != 0 ? 1 : 0);
    localparam int CW   = $clog2(FLEN + 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_q, par_d, out_q, out_d, frame_q, frame_d, done_q, done_d;
    logic             accept;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
    endfunction

    // Ready in IDLE and in the last-bit cycle, which lets frames chain without a gap.
    assign in_ready  = !rst && (state_q == IDLE || cnt_q == '0);
    assign accept    = in_valid && in_ready;
    assign busy      = state_q == SHIFT;
    assign ser_out   = out_q;
    assign ser_frame = frame_q;
    assign tx_done   = done_q;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        out_d   = 1'b0;
        frame_d = 1'b0;
        done_d  = 1'b0;
        if (accept) begin
            state_d = SHIFT;
            sr_d    = adv(in_data);
            cnt_d   = CW'(FLEN - 1);
            par_d   = ^in_data;
            out_d   = head(in_data);
            frame_d = 1'b1;
        end else if (state_q == SHIFT && cnt_q != '0) begin
            cnt_d   = cnt_q - CW'(1);
            frame_d = 1'b1;
            done_d  = cnt_q == CW'(1);
            if (PARITY_EN != 0 && cnt_q == CW'(1)) begin
                out_d = par_q;
            end else begin
                out_d = head(sr_q);
                sr_d  = adv(sr_q);
            end
        end else if (state_q == SHIFT) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            out_q   <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            out_q   <= out_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_piso_serial_tx.sv
// tb_piso_serial_tx: scoreboard bench; dut0 is MSB-first without parity,
// dut1 is LSB-first with even parity.
module tb_piso_serial_tx;
    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] in_data = 8'h5A;
    logic       v0 = 1'b1, v1 = 1'b0;
    logic       rdy0, so0, f0, td0, b0;
    logic       rdy1, so1, f1, td1, b1;
    logic [1:0] q0[$], q1[$];
    int         checks = 0, errors = 0;

    piso_serial_tx #(.WIDTH(8), .LSB_FIRST(0), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v0), .in_ready(rdy0),
        .ser_out(so0), .ser_frame(f0), .tx_done(td0), .busy(b0));

    piso_serial_tx #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v1), .in_ready(rdy1),
        .ser_out(so1), .ser_frame(f1), .tx_done(td1), .busy(b1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Expected entry per frame cycle: {ser_out, tx_done}.
    task automatic push(input int k, input logic [7:0] d);
        int   fl;
        logic b;
        fl = (k == 0) ? 8 : 9;
        for (int i = 0; i < fl; i++) begin
            b = (i == 8) ? ^d : (k == 1 ? d[i] : d[7-i]);
            if (k == 0) q0.push_back({b, i == fl - 1});
            else q1.push_back({b, i == fl - 1});
        end
    endtask

    task automatic mon(input int k, input logic so, input logic f, input logic td,
                       input logic rdy, input logic b);
        logic [1:0] e;
        int         sz;
        sz = (k == 0) ? q0.size() : q1.size();
        if (f) begin
            chk($sformatf("d%0d_unexpected_frame_bit", k), 32'(sz != 0), 1);
            if (sz != 0) begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("d%0d_ser_out", k), 32'(so), 32'(e[1]));
                chk($sformatf("d%0d_tx_done", k), 32'(td), 32'(e[0]));
                chk($sformatf("d%0d_in_ready_frame", k), 32'(rdy), 32'(e[0]));
                chk($sformatf("d%0d_busy_frame", k), 32'(b), 1);
            end
        end else begin
            chk($sformatf("d%0d_frame_gap", k), 0, 32'(sz != 0));
            chk($sformatf("d%0d_idle_ser_out", k), 32'(so), 0);
            chk($sformatf("d%0d_idle_tx_done", k), 32'(td), 0);
            chk($sformatf("d%0d_idle_in_ready", k), 32'(rdy), 1);
            chk($sformatf("d%0d_idle_busy", k), 32'(b), 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, so0, f0, td0, rdy0, b0);
            mon(1, so1, f1, td1, rdy1, b1);
        end
    end

    // Returns at the negedge after the accept edge, so in_data never changes at an edge.
    task automatic send(input int k, input logic [7:0] d);
        int n;
        n = 0;
        in_data = d;
        if (k == 0) v0 = 1'b1;
        else v1 = 1'b1;
        #1;
        while (!(k == 0 ? rdy0 : rdy1) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("ready_timeout", 32'(n < 100), 1);
        @(posedge clk);
        push(k, d);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || f0 || f1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < 200), 1);
        @(negedge clk);
    endtask

    initial begin
        #1;
        chk("reset_outputs", {28'd0, so0, f0, td0, b0}, 0);
        chk("reset_in_ready", 32'(rdy0), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("no_frame_in_reset", 32'(f0), 0);
        rst = 1'b0;
        send(0, 8'h5A);
        v0 = 1'b0;
        drain();
        send(0, 8'hA5);
        v0 = 1'b0;
        drain();
        send(1, 8'h07);
        v1 = 1'b0;
        drain();
        send(0, 8'h3C);
        send(0, 8'hC3);
        v0 = 1'b0;
        drain();
        send(0, 8'h00);
        v0 = 1'b0;
        in_data = 8'hFF;
        drain();
        send(0, 8'hFF);
        v0 = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        q0.delete();
        #1;
        chk("async_rst_ser_out", 32'(so0), 0);
        chk("async_rst_frame", 32'(f0), 0);
        chk("async_rst_tx_done", 32'(td0), 0);
        chk("async_rst_in_ready", 32'(rdy0), 0);
        chk("async_rst_busy", 32'(b0), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(0, 8'h81);
        v0 = 1'b0;
        drain();
        chk("queues_empty", 32'(q0.size() + q1.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
